// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: mode encodings, squeeze FSM states, round constants,
// the five-lane state type and small beat/rotation helpers.
package ascon_pkg;

   typedef enum logic [1:0] {
      SEL_AEAD128 = 2'b00,
      SEL_HASH256 = 2'b01,
      SEL_XOF128  = 2'b10,
      SEL_CXOF128 = 2'b11
   } sel_type_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EMIT    = 2'd1,
      ST_PERMUTE = 2'd2,
      ST_DONE    = 2'd3
   } sq_state_e;

   localparam int unsigned HASH256_OUT_BYTES = 32;
   localparam int unsigned MAX_ROUNDS        = 12;

   // Constant for round i of p12 is 0xF0 - 0x0F*i; pN uses the last N entries.
   localparam logic [7:0] ROUND_CONST [0:11] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
      8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
   };

   typedef struct packed {
      logic [63:0] x0;
      logic [63:0] x1;
      logic [63:0] x2;
      logic [63:0] x3;
      logic [63:0] x4;
   } ascon_state_t;

   function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Bytes carried by the next beat; a compare, so a huge remaining count saturates at 8.
   function automatic logic [3:0] beat_bytes(input logic [31:0] rem);
      return (rem >= 32'd8) ? 4'd8 : rem[3:0];
   endfunction

   function automatic logic [63:0] beat_mask(input logic [3:0] n);
      logic [63:0] m;
      for (int b = 0; b < 8; b++) begin
         m[8*b +: 8] = (4'(b) < n) ? 8'hFF : 8'h00;
      end
      return m;
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition on x2, 5-bit S-box layer, linear diffusion.
// State bus packs x0 in [319:256] down to x4 in [63:0].
module ascon_round
   import ascon_pkg::*;
(
   input  logic [319:0] state_i,
   input  logic [7:0]   rc_i,
   output logic [319:0] state_o
);

   ascon_state_t a;
   ascon_state_t b;
   ascon_state_t c;
   logic [63:0]  t0, t1, t2, t3, t4;

   always_comb begin
      a    = state_i;
      a.x2 = a.x2 ^ {56'h0, rc_i};

      // Bit-sliced S-box: input mix, chi-like core, output mix.
      a.x0 = a.x0 ^ a.x4;
      a.x4 = a.x4 ^ a.x3;
      a.x2 = a.x2 ^ a.x1;
      t0   = ~a.x0 & a.x1;
      t1   = ~a.x1 & a.x2;
      t2   = ~a.x2 & a.x3;
      t3   = ~a.x3 & a.x4;
      t4   = ~a.x4 & a.x0;
      b.x0 = a.x0 ^ t1;
      b.x1 = a.x1 ^ t2;
      b.x2 = a.x2 ^ t3;
      b.x3 = a.x3 ^ t4;
      b.x4 = a.x4 ^ t0;
      b.x1 = b.x1 ^ b.x0;
      b.x0 = b.x0 ^ b.x4;
      b.x3 = b.x3 ^ b.x2;
      b.x2 = ~b.x2;

      c.x0 = b.x0 ^ rotr64(b.x0, 19) ^ rotr64(b.x0, 28);
      c.x1 = b.x1 ^ rotr64(b.x1, 61) ^ rotr64(b.x1, 39);
      c.x2 = b.x2 ^ rotr64(b.x2, 1)  ^ rotr64(b.x2, 6);
      c.x3 = b.x3 ^ rotr64(b.x3, 10) ^ rotr64(b.x3, 17);
      c.x4 = b.x4 ^ rotr64(b.x4, 7)  ^ rotr64(b.x4, 41);
   end

   assign state_o = c;

endmodule

// File: rtl/ascon_squeeze.sv
// ASCON squeeze engine: emits digest/XOF output as 64-bit beats, running pN between beats.
// Define ASCON_SQUEEZE_UNROLL2_EN to chain two rounds per PERMUTE cycle (ROUNDS must be even).
module ascon_squeeze
   import ascon_pkg::*;
#(
   parameter int unsigned ROUNDS = 12
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  sel_type,
   input  logic [31:0] out_length,
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   output logic [63:0] out_data,
   output logic [3:0]  out_bytes,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [3:0] RC_BASE  = 4'(MAX_ROUNDS - ROUNDS);
   localparam logic [3:0] LAST_RND = 4'(ROUNDS);
`ifdef ASCON_SQUEEZE_UNROLL2_EN
   localparam logic [3:0] STEP     = 4'd2;
`else
   localparam logic [3:0] STEP     = 4'd1;
`endif

   // Stream handshake: a beat transfers on a rising edge where out_valid and out_ready are
   // both high; while out_valid is high without out_ready, the beat fields do not change.
   sq_state_e    state_q, state_d;
   ascon_state_t x_q, x_d;
   logic [31:0]  rem_q, rem_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [63:0]  out_data_q, out_data_d;
   logic [3:0]   out_bytes_q, out_bytes_d;
   logic         out_last_q, out_last_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         err_q, err_d;

   logic [3:0]   rc_idx0;
   logic [7:0]   rc0;
   logic [319:0] r0_out;
   ascon_state_t perm_next;
   logic [3:0]   rnd_next;
   logic         reject;
   logic [31:0]  load_rem;
   logic [3:0]   n_load;
   logic [3:0]   n_perm;

   assign rc_idx0 = RC_BASE + rnd_q;
   assign rc0     = (rc_idx0 < 4'd12) ? ROUND_CONST[rc_idx0] : 8'h00;

   ascon_round u_round0 (
      .state_i (x_q),
      .rc_i    (rc0),
      .state_o (r0_out)
   );

`ifdef ASCON_SQUEEZE_UNROLL2_EN
   logic [3:0]   rc_idx1;
   logic [7:0]   rc1;
   logic [319:0] r1_out;

   assign rc_idx1 = rc_idx0 + 4'd1;
   assign rc1     = (rc_idx1 < 4'd12) ? ROUND_CONST[rc_idx1] : 8'h00;

   ascon_round u_round1 (
      .state_i (r0_out),
      .rc_i    (rc1),
      .state_o (r1_out)
   );

   assign perm_next = r1_out;
`else
   assign perm_next = r0_out;
`endif

   assign reject   = (sel_type == SEL_AEAD128) || ((out_length == 32'd0) && sel_type[1]);
   assign load_rem = (sel_type == SEL_HASH256) ? 32'(HASH256_OUT_BYTES) : out_length;
   assign n_load   = beat_bytes(load_rem);
   assign n_perm   = beat_bytes(rem_q);
   assign rnd_next = rnd_q + STEP;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      rem_d       = rem_q;
      rnd_d       = rnd_q;
      out_data_d  = out_data_q;
      out_bytes_d = out_bytes_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (reject) begin
                  err_d = 1'b1;
               end else begin
                  x_d         = {x0_i, x1_i, x2_i, x3_i, x4_i};
                  rem_d       = load_rem;
                  state_d     = ST_EMIT;
                  out_valid_d = 1'b1;
                  out_bytes_d = n_load;
                  out_data_d  = x0_i & beat_mask(n_load);
                  out_last_d  = (load_rem <= 32'd8);
               end
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               rem_d       = rem_q - {28'h0, out_bytes_q};
               out_valid_d = 1'b0;
               out_data_d  = 64'h0;
               out_bytes_d = 4'h0;
               out_last_d  = 1'b0;
               // out_last_q already encodes remaining <= 8, i.e. this beat drains it.
               if (out_last_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_PERMUTE;
                  rnd_d   = 4'h0;
               end
            end
         end
         ST_PERMUTE: begin
            x_d   = perm_next;
            rnd_d = rnd_next;
            if (rnd_next >= LAST_RND) begin
               state_d     = ST_EMIT;
               rnd_d       = 4'h0;
               out_valid_d = 1'b1;
               out_bytes_d = n_perm;
               out_data_d  = perm_next.x0 & beat_mask(n_perm);
               out_last_d  = (rem_q <= 32'd8);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         rem_q       <= 32'h0;
         rnd_q       <= 4'h0;
         out_data_q  <= 64'h0;
         out_bytes_q <= 4'h0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         rem_q       <= rem_d;
         rnd_q       <= rnd_d;
         out_data_q  <= out_data_d;
         out_bytes_q <= out_bytes_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_bytes = out_bytes_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ascon_squeeze.sv
// Self-checking bench for ascon_squeeze: directed runs scored against a table-driven
// S-box model of the ASCON permutation, plus latency, stream-hold and reject checks.
module tb_ascon_squeeze;

`ifdef ASCON_SQUEEZE_UNROLL2_EN
   localparam int GAP = 6;
`else
   localparam int GAP = 12;
`endif

   localparam logic [4:0] SBOX [0:31] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  sel_type;
   logic [31:0] out_length;
   logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
   logic [63:0] out_data;
   logic [3:0]  out_bytes;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          start_edge;
   int          done_cyc;
   int          err_cnt;
   int          hs_cnt;
   int          stall_cnt;
   int          bp_req   = 0;

   logic [68:0] exp_q[$];
   logic [63:0] got_data[$];
   logic [3:0]  got_bytes[$];
   logic        got_last[$];

   logic [4:0][63:0] st_a, st_b, st_c;

   ascon_squeeze u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .sel_type   (sel_type),
      .out_length (out_length),
      .x0_i       (x0_i),
      .x1_i       (x1_i),
      .x2_i       (x2_i),
      .x3_i       (x3_i),
      .x4_i       (x4_i),
      .out_data   (out_data),
      .out_bytes  (out_bytes),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Clock and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: per-column S-box table lookup instead of bitwise equations.
   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [4:0][63:0] model_round(input logic [4:0][63:0] s_in, input logic [7:0] c);
      logic [4:0][63:0] s;
      logic [4:0][63:0] t;
      logic [4:0]       y;
      s = s_in;
      s[2][7:0] = s[2][7:0] ^ c;
      for (int j = 0; j < 64; j++) begin
         y = SBOX[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
         t[0][j] = y[4];
         t[1][j] = y[3];
         t[2][j] = y[2];
         t[3][j] = y[1];
         t[4][j] = y[0];
      end
      s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
      s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
      s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
      s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
      s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
      return s;
   endfunction

   function automatic logic [4:0][63:0] model_p12(input logic [4:0][63:0] s_in);
      logic [4:0][63:0] s;
      logic [7:0]       c;
      s = s_in;
      for (int i = 0; i < 12; i++) begin
         c = 8'hF0 - 8'(15 * i);
         s = model_round(s, c);
      end
      return s;
   endfunction

   function automatic logic [4:0][63:0] mk_state(input logic [63:0] a, b, c, d, e);
      logic [4:0][63:0] s;
      s[0] = a; s[1] = b; s[2] = c; s[3] = d; s[4] = e;
      return s;
   endfunction

   task automatic push_expected(input logic [1:0] sel, input logic [31:0] len,
                                input logic [4:0][63:0] st_in);
      logic [4:0][63:0] st;
      logic [31:0]      rem;
      logic [3:0]       n;
      logic [63:0]      d;
      st  = st_in;
      rem = (sel == 2'b01) ? 32'd32 : len;
      while (rem != 0) begin
         n = (rem > 8) ? 4'd8 : rem[3:0];
         d = 64'h0;
         for (int b = 0; b < 8; b++) begin
            if (b < int'(n)) d[8*b +: 8] = st[0][8*b +: 8];
         end
         exp_q.push_back({(rem <= 8), n, d});
         rem = rem - 32'(n);
         if (rem != 0) st = model_p12(st);
      end
   endtask

   // Driver tasks
   task automatic do_start(input logic [1:0] sel, input logic [31:0] len,
                           input logic [4:0][63:0] st, input bit expect_run);
      @(negedge clk);
      start      = 1'b1;
      sel_type   = sel;
      out_length = len;
      x0_i = st[0]; x1_i = st[1]; x2_i = st[2]; x3_i = st[3]; x4_i = st[4];
      start_edge = cyc + 1;
      if (expect_run) push_expected(sel, len, st);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
      check_eq({tag, "_exp_q_empty"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check_eq({tag, "_busy_after_done"}, 64'(busy), 64'd0);
   endtask

   task automatic clear_logs();
      got_data.delete();
      got_bytes.delete();
      got_last.delete();
      err_cnt   = 0;
      stall_cnt = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_out_data"},  out_data,         64'd0);
      check_eq({tag, "_out_bytes"}, 64'(out_bytes),   64'd0);
      check_eq({tag, "_out_last"},  64'(out_last),    64'd0);
      check_eq({tag, "_out_valid"}, 64'(out_valid),   64'd0);
      check_eq({tag, "_busy"},      64'(busy),        64'd0);
      check_eq({tag, "_done"},      64'(done),        64'd0);
      check_eq({tag, "_err"},       64'(err),         64'd0);
   endtask

   task automatic reject_case(input string tag, input logic [1:0] sel, input logic [31:0] len);
      do_start(sel, len, st_a, 1'b0);
      check_eq({tag, "_err_pulse"}, 64'(err),       64'd1);
      check_eq({tag, "_busy"},      64'(busy),      64'd0);
      check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check_eq({tag, "_err_cleared"}, 64'(err), 64'd0);
   endtask

   // Ready driver: holds out_ready low for bp_req cycles of a pending beat
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (bp_req > 0 && out_valid) begin
            out_ready = 1'b0;
            bp_req--;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic        pv, pr, pl;
      logic [63:0] pd;
      logic [3:0]  pb;
      logic [68:0] e;
      bit          gap_armed;
      int          lowcnt;
      pv = 0; pr = 0; pl = 0; pd = 0; pb = 0; gap_armed = 0; lowcnt = 0;
      hs_cnt = 0; err_cnt = 0; stall_cnt = 0; done_cyc = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            pv = 0;
            gap_armed = 0;
            lowcnt = 0;
         end else begin
            if (pv && !pr) begin
               check_eq("hold_valid", 64'(out_valid), 64'd1);
               check_eq("hold_data",  out_data,       pd);
               check_eq("hold_bytes", 64'(out_bytes), 64'(pb));
               check_eq("hold_last",  64'(out_last),  64'(pl));
            end
            if (gap_armed) begin
               if (!out_valid) lowcnt++;
               else begin
                  check_eq("permute_gap", 64'(lowcnt), 64'(GAP));
                  gap_armed = 0;
               end
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
               hs_cnt++;
               got_data.push_back(out_data);
               got_bytes.push_back(out_bytes);
               got_last.push_back(out_last);
               if (exp_q.size() == 0) begin
                  check_eq("extra_beat", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("beat_data",  out_data,       e[63:0]);
                  check_eq("beat_bytes", 64'(out_bytes), 64'(e[67:64]));
                  check_eq("beat_last",  64'(out_last),  64'(e[68]));
               end
               if (!out_last) begin
                  gap_armed = 1;
                  lowcnt = 0;
               end
            end
            if (err) err_cnt++;
            if (done) done_cyc = cyc;
            pv = out_valid; pr = out_ready; pd = out_data; pb = out_bytes; pl = out_last;
         end
      end
   end

   // Main sequence
   initial begin
      int base;
      bit seen;
      rst_n = 1'b0; start = 1'b0; sel_type = 2'b00; out_length = 32'd0;
      x0_i = 0; x1_i = 0; x2_i = 0; x3_i = 0; x4_i = 0;
      st_a = mk_state(64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                      64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d);
      st_b = mk_state(64'h1111111111111111, 64'h2222222222222222, 64'h4444444444444444,
                      64'h8888888888888888, 64'h0000000000000001);
      st_c = mk_state(64'ha5a5a5a55a5a5a5a, 64'h0, 64'hffffffffffffffff,
                      64'h13579bdf02468ace, 64'h7f7f7f7f80808080);

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Hash256 with a start pulse while busy that must be ignored
      clear_logs();
      do_start(2'b01, 32'd5, st_a, 1'b1);
      check_eq("hash_first_valid", 64'(out_valid), 64'd1);
      repeat (4) @(negedge clk);
      start = 1'b1; sel_type = 2'b00;
      @(negedge clk);
      start = 1'b0;
      wait_done("hash", 200);
      check_eq("hash_done_latency", 64'(done_cyc - start_edge), 64'(1 + 3 * (GAP + 1)));
      check_eq("hash_nbeats", 64'(got_data.size()), 64'd4);
      for (int i = 0; i < got_bytes.size(); i++) begin
         check_eq($sformatf("hash_bytes%0d", i), 64'(got_bytes[i]), 64'd8);
         check_eq($sformatf("hash_last%0d", i),  64'(got_last[i]),  64'(i == 3));
      end
      check_eq("busy_start_ignored_err", 64'(err_cnt), 64'd0);

      // XOF128, 13 bytes: 8 + 5
      clear_logs();
      do_start(2'b10, 32'd13, st_b, 1'b1);
      wait_done("xof13", 200);
      check_eq("xof13_nbeats", 64'(got_data.size()), 64'd2);
      if (got_data.size() == 2) begin
         check_eq("xof13_b1_bytes",   64'(got_bytes[0]), 64'd8);
         check_eq("xof13_b2_bytes",   64'(got_bytes[1]), 64'd5);
         check_eq("xof13_b2_last",    64'(got_last[1]),  64'd1);
         check_eq("xof13_b2_hi_zero", 64'(got_data[1][63:40]), 64'd0);
      end

      // Rejected starts
      clear_logs();
      reject_case("rej_aead", 2'b00, 32'd16);
      reject_case("rej_xof0", 2'b10, 32'd0);
      reject_case("rej_cxof0", 2'b11, 32'd0);

      // Backpressure on the first beat of a 20-byte XOF run
      clear_logs();
      bp_req = 5;
      do_start(2'b10, 32'd20, st_c, 1'b1);
      wait_done("bp", 300);
      check_eq("bp_stall_cycles", 64'(stall_cnt), 64'd5);
      check_eq("bp_nbeats", 64'(got_data.size()), 64'd3);

      // Boundary lengths: exactly one full beat, and a single byte via CXOF128
      clear_logs();
      do_start(2'b10, 32'd8, st_b, 1'b1);
      wait_done("xof8", 100);
      check_eq("xof8_nbeats", 64'(got_data.size()), 64'd1);
      clear_logs();
      do_start(2'b11, 32'd1, st_c, 1'b1);
      wait_done("cxof1", 100);
      check_eq("cxof1_hi_zero", (got_data.size() == 1) ? got_data[0][63:8] : 64'hdead, 64'd0);

      // Reset during PERMUTE, then a fresh Hash256 run
      clear_logs();
      base = hs_cnt;
      do_start(2'b01, 32'd0, st_a, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (hs_cnt > base) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("rst_first_hs", 64'(seen), 64'd1);
      repeat (5) @(negedge clk);
      check_eq("rst_in_permute_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_logs();
      do_start(2'b01, 32'd0, st_a, 1'b1);
      wait_done("hash_after_rst", 200);
      check_eq("hash_after_rst_nbeats", 64'(got_data.size()), 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
